context_scheduler: RTL and testbench

CONTEXT_SCHEDULER -- requirements
Module: context_scheduler

---
 rtl/context_scheduler_if.sv | 37 +++
 rtl/context_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_context_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/context_scheduler_if.sv
// Bundles the launch, retire, memory-completion and status signals of the
// context scheduler. The master side (core or testbench) drives requests;
// the slave side is the scheduler itself.
interface context_scheduler_if #(
  parameter int NUM_CONTEXTS = 4,
  parameter int PRI_BITS     = 2
);
  localparam int CTX_W = $clog2(NUM_CONTEXTS);

  logic                             start;
  logic [NUM_CONTEXTS-1:0]          context_enable;
  logic [NUM_CONTEXTS*PRI_BITS-1:0] context_priority;
  logic                             retire_valid;
  logic                             retire_ret;
  logic                             retire_mem;
  logic [NUM_CONTEXTS-1:0]          mem_complete;
  logic [CTX_W-1:0]                 active_context;
  logic                             active_valid;
  logic                             switch_pulse;
  logic [NUM_CONTEXTS-1:0]          ctx_waiting;
  logic [15:0]                      switch_count;
  logic                             done;

  modport master (
    output start, context_enable, context_priority,
    output retire_valid, retire_ret, retire_mem, mem_complete,
    input  active_context, active_valid, switch_pulse,
    input  ctx_waiting, switch_count, done
  );

  modport slave (
    input  start, context_enable, context_priority,
    input  retire_valid, retire_ret, retire_mem, mem_complete,
    output active_context, active_valid, switch_pulse,
    output ctx_waiting, switch_count, done
  );
endinterface

// File: rtl/context_scheduler.sv
// Hardware context scheduler: tracks per-context state, picks the highest
// priority READY context (round-robin among equals), charges a fixed
// penalty on every context change and reports completion.
module context_scheduler #(
  parameter int NUM_CONTEXTS   = 4,
  parameter int PRI_BITS       = 2,
  parameter int SWITCH_PENALTY = 1,
  parameter int PREEMPT        = 0
) (
  input logic               clk,
  input logic               reset,
  context_scheduler_if.slave bus
);
  localparam int CTX_W = $clog2(NUM_CONTEXTS);

  typedef enum logic [2:0] {
    CTX_IDLE, CTX_READY, CTX_RUNNING, CTX_WAITING, CTX_FINISHED
  } ctx_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SWITCH, S_RUN, S_DONE
  } fsm_state_e;

  fsm_state_e          state_q, state_d;
  ctx_state_e          ctx_state_q [NUM_CONTEXTS];
  ctx_state_e          ctx_state_d [NUM_CONTEXTS];
  logic [PRI_BITS-1:0] pri_q [NUM_CONTEXTS];
  logic [PRI_BITS-1:0] pri_d [NUM_CONTEXTS];
  logic [CTX_W-1:0]    active_q, active_d;
  logic [CTX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                switch_pulse_q, switch_pulse_d;
  logic [15:0]         switch_count_q, switch_count_d;
  logic [2:0]          penalty_q, penalty_d;

  logic                sel_found;
  logic [CTX_W-1:0]    sel_idx;
  logic [PRI_BITS-1:0] sel_pri;
  logic [CTX_W:0]      scan_idx;
  logic                higher_ready;
  logic                all_finished;
  logic [NUM_CONTEXTS-1:0] waiting_vec;

  // Scan READY contexts from the round-robin pointer; strict '>' keeps the first equal-priority hit.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pri   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CONTEXTS; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CTX_W+1)'(i);
      if (scan_idx >= (CTX_W+1)'(NUM_CONTEXTS)) begin
        scan_idx = scan_idx - (CTX_W+1)'(NUM_CONTEXTS);
      end
      if (ctx_state_q[scan_idx[CTX_W-1:0]] == CTX_READY &&
          (!sel_found || pri_q[scan_idx[CTX_W-1:0]] > sel_pri)) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx[CTX_W-1:0];
        sel_pri   = pri_q[scan_idx[CTX_W-1:0]];
      end
    end
  end

  // Summary flags over all contexts: preemption candidate, completion and waiting mask.
  always_comb begin
    higher_ready = 1'b0;
    all_finished = 1'b1;
    waiting_vec  = '0;
    for (int i = 0; i < NUM_CONTEXTS; i++) begin
      if (ctx_state_q[i] == CTX_READY && pri_q[i] > pri_q[active_q]) begin
        higher_ready = 1'b1;
      end
      if (ctx_state_q[i] != CTX_FINISHED) begin
        all_finished = 1'b0;
      end
      waiting_vec[i] = (ctx_state_q[i] == CTX_WAITING);
    end
  end

  // Next-state logic for the top FSM and every per-context state.
  always_comb begin
    state_d        = state_q;
    ctx_state_d    = ctx_state_q;
    pri_d          = pri_q;
    active_d       = active_q;
    rr_ptr_d       = rr_ptr_q;
    switch_pulse_d = 1'b0;
    switch_count_d = switch_count_q;
    penalty_d      = penalty_q;

    for (int i = 0; i < NUM_CONTEXTS; i++) begin
      if (ctx_state_q[i] == CTX_WAITING && bus.mem_complete[i]) begin
        ctx_state_d[i] = CTX_READY;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_CONTEXTS; i++) begin
            ctx_state_d[i] = bus.context_enable[i] ? CTX_READY : CTX_FINISHED;
            pri_d[i]       = bus.context_priority[i*PRI_BITS +: PRI_BITS];
          end
          state_d = (|bus.context_enable) ? S_SELECT : S_DONE;
        end
      end
      S_SELECT: begin
        if (all_finished) begin
          state_d = S_DONE;
        end else if (sel_found) begin
          ctx_state_d[sel_idx] = CTX_RUNNING;
          rr_ptr_d = (sel_idx == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : sel_idx + CTX_W'(1);
          if (sel_idx == active_q) begin
            state_d = S_RUN;
          end else begin
            active_d       = sel_idx;
            switch_pulse_d = 1'b1;
            if (switch_count_q != 16'hFFFF) begin
              switch_count_d = switch_count_q + 16'd1;
            end
            if (SWITCH_PENALTY == 0) begin
              state_d = S_RUN;
            end else begin
              state_d   = S_SWITCH;
              penalty_d = 3'(SWITCH_PENALTY - 1);
            end
          end
        end
      end
      S_SWITCH: begin
        if (penalty_q == 3'd0) begin
          state_d = S_RUN;
        end else begin
          penalty_d = penalty_q - 3'd1;
        end
      end
      S_RUN: begin
        if (bus.retire_valid) begin
          if (bus.retire_ret) begin
            ctx_state_d[active_q] = CTX_FINISHED;
            state_d               = S_SELECT;
          end else if (bus.retire_mem) begin
            ctx_state_d[active_q] = bus.mem_complete[active_q] ? CTX_READY : CTX_WAITING;
            state_d               = S_SELECT;
          end else if (PREEMPT != 0 && higher_ready) begin
            ctx_state_d[active_q] = CTX_READY;
            state_d               = S_SELECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      active_q       <= '0;
      rr_ptr_q       <= '0;
      switch_pulse_q <= 1'b0;
      switch_count_q <= '0;
      penalty_q      <= '0;
      for (int i = 0; i < NUM_CONTEXTS; i++) begin
        ctx_state_q[i] <= CTX_IDLE;
        pri_q[i]       <= '0;
      end
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      rr_ptr_q       <= rr_ptr_d;
      switch_pulse_q <= switch_pulse_d;
      switch_count_q <= switch_count_d;
      penalty_q      <= penalty_d;
      for (int i = 0; i < NUM_CONTEXTS; i++) begin
        ctx_state_q[i] <= ctx_state_d[i];
        pri_q[i]       <= pri_d[i];
      end
    end
  end

  // Status outputs are pure functions of registered state.
  always_comb begin
    bus.active_context = active_q;
    bus.active_valid   = (state_q == S_RUN);
    bus.switch_pulse   = switch_pulse_q;
    bus.switch_count   = switch_count_q;
    bus.done           = (state_q == S_DONE);
    bus.ctx_waiting    = waiting_vec;
  end
endmodule

// File: tb/tb_context_scheduler.sv
// Directed-vector bench for context_scheduler (4 contexts, penalty 1, preemption on).
module tb_context_scheduler;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic clk;
  logic reset;

  context_scheduler_if #(.NUM_CONTEXTS(4), .PRI_BITS(2)) bus ();

  context_scheduler #(
    .NUM_CONTEXTS(4), .PRI_BITS(2), .SWITCH_PENALTY(1), .PREEMPT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        start;
    logic [3:0]  enable;
    logic [7:0]  prio;
    logic        rv;
    logic        rret;
    logic        rmem;
    logic [3:0]  mc;
    logic [1:0]  exp_ac;
    logic        exp_av;
    logic        exp_sp;
    logic [3:0]  exp_wt;
    logic        exp_dn;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic st, input logic [3:0] en, input logic [7:0] pr,
                              input logic rv, input logic rr, input logic rm, input logic [3:0] mc,
                              input logic [1:0] ac, input logic av, input logic sp,
                              input logic [3:0] wt, input logic dn, input logic [15:0] cnt);
    vec_t v;
    v.start = st; v.enable = en; v.prio = pr; v.rv = rv; v.rret = rr; v.rmem = rm; v.mc = mc;
    v.exp_ac = ac; v.exp_av = av; v.exp_sp = sp; v.exp_wt = wt; v.exp_dn = dn; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic st, input logic [3:0] en, input logic [7:0] pr,
                             input logic rv, input logic rr, input logic rm, input logic [3:0] mc);
    bus.start            = st;
    bus.context_enable   = en;
    bus.context_priority = pr;
    bus.retire_valid     = rv;
    bus.retire_ret       = rr;
    bus.retire_mem       = rm;
    bus.mem_complete     = mc;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v.start, v.enable, v.prio, v.rv, v.rret, v.rmem, v.mc);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] ac, input logic av, input logic sp,
                          input logic [3:0] wt, input logic dn, input logic [15:0] cnt);
    checkOutput({tag, ".active_context"}, 16'(bus.active_context), 16'(ac));
    checkOutput({tag, ".active_valid"},   16'(bus.active_valid),   16'(av));
    checkOutput({tag, ".switch_pulse"},   16'(bus.switch_pulse),   16'(sp));
    checkOutput({tag, ".ctx_waiting"},    16'(bus.ctx_waiting),    16'(wt));
    checkOutput({tag, ".done"},           16'(bus.done),           16'(dn));
    checkOutput({tag, ".switch_count"},   bus.switch_count,        cnt);
  endtask

  initial begin
    int pulses;
    int exp_sat;

    // Vector table: inputs for one cycle, then outputs expected after that edge.
    //                     st en       prio   rv rr rm mc         ac    av sp wt       dn cnt
    vecs.push_back(mk(L, 4'b0000, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0)); // 0 idle
    vecs.push_back(mk(H, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0)); // 1 launch
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd0)); // 2 ctx0 no switch
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, L, H, 4'b0000, 2'd0, L, L, 4'b0001, L, 16'd0)); // 3 ctx0 mem
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd1, L, H, 4'b0001, L, 16'd1)); // 4 switch to 1
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd1, H, L, 4'b0001, L, 16'd1)); // 5 run
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, L, L, 4'b0000, 2'd1, H, L, 4'b0001, L, 16'd1)); // 6 plain retire
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0001, 2'd1, H, L, 4'b0000, L, 16'd1)); // 7 ctx0 wakes
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, L, L, 4'b0000, 2'd1, H, L, 4'b0000, L, 16'd1)); // 8 equal pri stays
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, H, L, 4'b0000, 2'd1, L, L, 4'b0000, L, 16'd1)); // 9 ctx1 ret
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, L, H, 4'b0000, L, 16'd2)); // 10 switch to 0
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd2)); // 11 run
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, H, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd2)); // 12 ctx0 ret
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd2)); // 13 done
    vecs.push_back(mk(L, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd2)); // 14 done held
    vecs.push_back(mk(L, 4'b0011, 8'h00, H, H, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd2)); // 15 retire ignored
    vecs.push_back(mk(H, 4'b0000, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd2)); // 16 empty launch
    vecs.push_back(mk(H, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd2)); // 17 relaunch {3,1}
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd2)); // 18 ctx0 wins
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0000, 2'd0, L, L, 4'b0001, L, 16'd2)); // 19 ctx0 mem
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, L, H, 4'b0001, L, 16'd3)); // 20 switch to 1
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0001, 2'd1, H, L, 4'b0000, L, 16'd3)); // 21 ctx0 ready
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, L, 4'b0000, 2'd1, L, L, 4'b0000, L, 16'd3)); // 22 preempt
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, H, 4'b0000, L, 16'd4)); // 23 back to 0
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd4)); // 24 run
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0000, 2'd0, L, L, 4'b0001, L, 16'd4)); // 25 ctx0 mem
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, L, H, 4'b0001, L, 16'd5)); // 26 switch to 1
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, H, L, 4'b0001, L, 16'd5)); // 27 run
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0000, 2'd1, L, L, 4'b0011, L, 16'd5)); // 28 both waiting
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0001, 2'd1, L, L, 4'b0010, L, 16'd5)); // 29 ctx0 wakes
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, H, 4'b0010, L, 16'd6)); // 30 switch to 0
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, H, L, 4'b0010, L, 16'd6)); // 31 run
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0000, 2'd0, L, L, 4'b0011, L, 16'd6)); // 32 both waiting
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, L, 4'b0011, L, 16'd6)); // 33 stall
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, L, 4'b0011, L, 16'd6)); // 34 stall
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0010, 2'd0, L, L, 4'b0001, L, 16'd6)); // 35 ctx1 wakes
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, L, H, 4'b0001, L, 16'd7)); // 36 switch to 1
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, H, L, 4'b0001, L, 16'd7)); // 37 run after penalty
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0010, 2'd1, L, L, 4'b0001, L, 16'd7)); // 38 mem+complete
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd1, H, L, 4'b0001, L, 16'd7)); // 39 reselect 1
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0110, 2'd1, H, L, 4'b0001, L, 16'd7)); // 40 stray complete
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, H, H, 4'b0000, 2'd1, L, L, 4'b0001, L, 16'd7)); // 41 ret wins
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, L, H, 4'b0000, 2'd1, L, L, 4'b0001, L, 16'd7)); // 42 retire in SELECT
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0001, 2'd1, L, L, 4'b0000, L, 16'd7)); // 43 ctx0 wakes
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, H, 4'b0000, L, 16'd8)); // 44 switch to 0
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd8)); // 45 run
    vecs.push_back(mk(H, 4'b1111, 8'hFF, L, L, L, 4'b0000, 2'd0, H, L, 4'b0000, L, 16'd8)); // 46 start ignored
    vecs.push_back(mk(L, 4'b0011, 8'h07, H, H, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd8)); // 47 ctx0 ret
    vecs.push_back(mk(L, 4'b0011, 8'h07, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd8)); // 48 done
    vecs.push_back(mk(H, 4'b0000, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, H, 16'd8)); // 49 empty launch

    // Reset state.
    reset = 1'b0;
    driveInputs(L, 4'b0000, 8'h00, L, L, L, 4'b0000);
    @(posedge clk);
    #1;
    checkAll("reset", 2'd0, L, L, 4'b0000, L, 16'd0);
    #2;
    reset = 1'b1;

    // Table-driven main sequence.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("v%0d", i), vecs[i].exp_ac, vecs[i].exp_av, vecs[i].exp_sp,
               vecs[i].exp_wt, vecs[i].exp_dn, vecs[i].exp_cnt);
    end

    // Asynchronous reset while in SWITCH.
    applyStimulus(mk(H, 4'b0010, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0));
    applyStimulus(mk(L, 4'b0010, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0));
    checkOutput("switch.active_context", 16'(bus.active_context), 16'd1);
    checkOutput("switch.switch_count", bus.switch_count, 16'd9);
    checkOutput("switch.switch_pulse", 16'(bus.switch_pulse), 16'd1);
    #1;
    reset = 1'b0;
    #1;
    checkAll("async_reset", 2'd0, L, L, 4'b0000, L, 16'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    applyStimulus(mk(L, 4'b0000, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0));
    checkAll("post_reset", 2'd0, L, L, 4'b0000, L, 16'd0);

    // Counter saturation from a preloaded value near the top.
    force dut.switch_count_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.switch_count_q;
    checkOutput("sat.preload", bus.switch_count, 16'hFFFD);
    applyStimulus(mk(H, 4'b0011, 8'h00, L, L, L, 4'b0000, 2'd0, L, L, 4'b0000, L, 16'd0));
    pulses = 0;
    for (int cyc = 0; cyc < 40 && pulses < 4; cyc++) begin
      if (bus.active_valid) begin
        driveInputs(L, 4'b0011, 8'h00, H, L, H, 4'b0001 << bus.active_context);
      end else begin
        driveInputs(L, 4'b0011, 8'h00, L, L, L, 4'b0000);
      end
      @(posedge clk);
      #1;
      if (bus.switch_pulse) begin
        pulses++;
        exp_sat = 'hFFFD + pulses;
        if (exp_sat > 'hFFFF) exp_sat = 'hFFFF;
        checkOutput($sformatf("sat.pulse%0d", pulses), bus.switch_count, 16'(exp_sat));
      end
    end
    checkOutput("sat.pulses_seen", 16'(pulses), 16'd4);
    driveInputs(L, 4'b0000, 8'h00, L, L, L, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
